descriptor_matcher: RTL and testbench
=====================================

# descriptor_matcher

Downstream consumer of the 32-entry × 1280-bit descriptor store in the matching path. On `start`, it latches one query descriptor of 128 × 10-bit elements and scans stored entries 0..num_entries-1 through the store's combinational read port. For each entry it accumulates the sum of absolute differences (SAD) against the query, 16 lanes per cycle. It reports the best index, the best and second-best distances, and a Lowe-style ratio-test verdict.

## Interface
- `ELEM_W`, 10, bits per descriptor element
- `N_ELEM`, 128, elements per descriptor
- `ADDR_WIDTH`, 5, store address width (up to 32 entries)
- `LANES`, 16, elements compared per cycle; must divide `N_ELEM`
- `DIST_W`, 17, distance width; holds `N_ELEM*(2^ELEM_W-1)` = 130944
- `RATIO_NUM`, 8, ratio-test numerator
- `RATIO_DEN`, 10, ratio-test denominator
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a search; honoured only in IDLE.
- `query` in `N_ELEM*ELEM_W`: query descriptor; sampled on the accepted `start`.
- `num_entries` in `ADDR_WIDTH+1`: entries to scan, 0..32; sampled on the accepted `start`.
- `sram_addr` out `ADDR_WIDTH`: read address to the store.
- `sram_q` in `N_ELEM*ELEM_W`: store read data, valid in the same cycle as `sram_addr`.
- `busy` out 1: high from the cycle after an accepted `start` through FINISH.
- `done` out 1: one-cycle pulse when results are valid.
- `best_idx` out `ADDR_WIDTH`: index of the minimum-distance entry.
- `best_dist` out `DIST_W`: minimum distance.
- `second_dist` out `DIST_W`: second-smallest distance.
- `match_valid` out 1: ratio test passed.

## Operation
- States and transitions:
  - IDLE → SCAN on `start`, or IDLE → FINISH if `num_entries`==0.
  - SCAN → FINISH after the last beat of the last entry.
  - FINISH → IDLE unconditionally.
- Element k occupies bits `[k*ELEM_W +: ELEM_W]`. Beat b, 0..`N_ELEM/LANES`-1, covers elements `b*LANES` .. `b*LANES+LANES-1`.
- During SCAN:
  - `sram_addr` equals the entry counter and is held for all 8 beats of that entry.
  - Each beat adds the `LANES` absolute differences to `acc`, unsigned.
  - `acc` is cleared at the first beat of each entry.
- On the final beat, `d = acc + beat_sum` is compared in the same cycle:
  - If `d < best`: `second ← best`, `best ← d`, `best_idx ← entry`.
  - Else if `d < second`: `second ← d`.
  - Ties go to the lower index; a tie with `best` lands in `second`.
- At search start, `best` and `second` initialise to all-ones and `best_idx` to 0.
- In FINISH:
  - `match_valid = (best*RATIO_DEN < second*RATIO_NUM)`, computed in `DIST_W+4` bits with no overflow.
  - `done` pulses.
- Results hold until the next accepted `start`.
- `start` while busy is ignored.
- The external writer must keep the store's `we` low while `busy`=1. This block never writes the store.
- `sram_addr` reads 0 in IDLE.

## Timing
- Reset values: state IDLE; all outputs 0 except `best_dist` and `second_dist`, which reset to all-ones. `match_valid` is 0.
- With `start` accepted at edge 0:
  - SCAN occupies cycles 1 .. 8N, where N = `num_entries`.
  - `done` is high in cycle 8N+1.
  - Next `start` is accepted at the earliest in cycle 8N+2.
  - If N=0: `done` is high in cycle 1, distances are all-ones, and `match_valid`=0.
- N=1: `second_dist` stays all-ones; `match_valid` is evaluated normally.
- Asserting `rst_n` low mid-scan returns to IDLE immediately with the reset values. No `done` pulse is produced.
- The SAD path is combinational from `sram_q`, through the lane adder, into `acc`/compare: one stage, one register level.

## Structure
- Shared package `matching_pkg`:
  - `ELEM_W`, `N_ELEM`, `DESC_W` (=1280), `DIST_W`
  - state enum {IDLE, SCAN, FINISH}
  - the element-slice helper function
- Sub-module `sad_lane_sum`: combinational; `LANES` absolute differences and an adder tree; output width `ELEM_W + log2(LANES)`.
- Top level contains the FSM, beat and entry counters, accumulator, best/second tracking, and the ratio compare.

## Test plan
- Identical descriptor at entry 3 of 4; every element of the other entries is +5 from the query → `best_idx`=3, `best_dist`=0, `second_dist`=640, `match_valid`=1, `done` in cycle 33.
- `num_entries`=0 → `done` in cycle 1, `best_dist`=`second_dist`=131071, `match_valid`=0, `sram_addr` stays 0.
- Entries 0 and 1 both at distance 128 → `best_idx`=0, `best_dist`=`second_dist`=128, `match_valid`=0.
- Ratio boundary: best 80 / second 100 → `match_valid`=0; best 79 / second 100 → `match_valid`=1.
- All-zero query against 32 entries of all-1023:
  - addresses step 0..31, each held 8 cycles;
  - `best_dist`=130944, `best_idx`=0, `done` in cycle 257.
- Re-pulse `start` at cycle 5 (ignored), then assert `rst_n` low at cycle 10 → outputs return to reset values, no `done`. A fresh search afterwards completes normally.

Source files
------------

// File: rtl/matching_pkg.sv
// Shared definitions for the descriptor matching path: element geometry,
// distance width, controller states and the element-slice helper.
package matching_pkg;

   localparam int ELEM_W = 10;
   localparam int N_ELEM = 128;
   localparam int DESC_W = ELEM_W * N_ELEM;
   localparam int DIST_W = 17;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Element k of a packed descriptor lives at bits [k*ELEM_W +: ELEM_W].
   function automatic logic [ELEM_W-1:0] elem_slice(input logic [DESC_W-1:0] desc,
                                                    input int                k);
      return desc[k*ELEM_W +: ELEM_W];
   endfunction

endpackage

// File: rtl/sad_lane_sum.sv
// Combinational SAD of one beat: LANES absolute differences between the
// query and the stored descriptor, reduced by a balanced adder tree.
module sad_lane_sum
   import matching_pkg::*;
#(
   parameter int LANES  = 16,
   parameter int BEAT_W = 3,
   parameter int SUM_W  = matching_pkg::ELEM_W + $clog2(LANES)
) (
   input  logic [DESC_W-1:0] a,
   input  logic [DESC_W-1:0] b,
   input  logic [BEAT_W-1:0] beat,
   output logic [SUM_W-1:0]  sum
);

   localparam int LEVELS = $clog2(LANES);

   logic [SUM_W-1:0]  node [LANES];
   logic [ELEM_W-1:0] ea;
   logic [ELEM_W-1:0] eb;

   // Leaves hold |a-b| per lane; each level folds pairs in place toward node[0].
   always_comb begin
      ea = '0;
      eb = '0;
      for (int i = 0; i < LANES; i++) begin
         ea      = elem_slice(a, int'(beat) * LANES + i);
         eb      = elem_slice(b, int'(beat) * LANES + i);
         node[i] = SUM_W'((ea >= eb) ? (ea - eb) : (eb - ea));
      end
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = 0; i < (LANES >> (l + 1)); i++) begin
            node[i * (2 << l)] = node[i * (2 << l)] + node[i * (2 << l) + (1 << l)];
         end
      end
      sum = node[0];
   end

endmodule

// File: rtl/descriptor_matcher.sv
// Brute-force nearest-neighbour search over the descriptor store with a
// ratio test on the two best distances.
//
//   state  | meaning
//   IDLE   | waiting for start; results of the last search held
//   SCAN   | reading entries, one beat of LANES elements per cycle
//   FINISH | results final, done pulses, ratio verdict captured
module descriptor_matcher #(
   parameter int ELEM_W     = 10,
   parameter int N_ELEM     = 128,
   parameter int ADDR_WIDTH = 5,
   parameter int LANES      = 16,
   parameter int DIST_W     = 17,
   parameter int RATIO_NUM  = 8,
   parameter int RATIO_DEN  = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [N_ELEM*ELEM_W-1:0]   query,
   input  logic [ADDR_WIDTH:0]        num_entries,
   output logic [ADDR_WIDTH-1:0]      sram_addr,
   input  logic [N_ELEM*ELEM_W-1:0]   sram_q,
   output logic                       busy,
   output logic                       done,
   output logic [ADDR_WIDTH-1:0]      best_idx,
   output logic [DIST_W-1:0]          best_dist,
   output logic [DIST_W-1:0]          second_dist,
   output logic                       match_valid
);

   import matching_pkg::*;

   localparam int BEATS  = N_ELEM / LANES;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int SUM_W  = ELEM_W + $clog2(LANES);
   localparam int PROD_W = DIST_W + 4;

   state_t                   state;
   logic [BEAT_W-1:0]        beat;
   logic [ADDR_WIDTH-1:0]    entry;
   logic [ADDR_WIDTH:0]      num_r;
   logic [N_ELEM*ELEM_W-1:0] query_r;
   logic [DIST_W-1:0]        acc;
   logic [DIST_W-1:0]        best;
   logic [DIST_W-1:0]        second;
   logic [ADDR_WIDTH-1:0]    idx;
   logic                     mv_r;
   logic [SUM_W-1:0]         beat_sum;
   logic [DIST_W-1:0]        d;
   logic                     last_beat;
   logic                     last_entry;
   logic                     ratio_ok;

   sad_lane_sum #(
      .LANES  (LANES),
      .BEAT_W (BEAT_W),
      .SUM_W  (SUM_W)
   ) u_sad (
      .a    (query_r),
      .b    (sram_q),
      .beat (beat),
      .sum  (beat_sum)
   );

   assign last_beat  = (beat == BEAT_W'(BEATS - 1));
   assign last_entry = ({1'b0, entry} == (num_r - 1'b1));

   // Beat 0 starts from zero so acc never needs an explicit clear cycle.
   assign d = ((beat == '0) ? '0 : acc) + DIST_W'(beat_sum);

   // Widened products: all-ones best times RATIO_DEN must not wrap.
   assign ratio_ok = (PROD_W'(best) * PROD_W'(RATIO_DEN)) < (PROD_W'(second) * PROD_W'(RATIO_NUM));

   assign sram_addr   = entry;
   assign busy        = (state != IDLE);
   assign done        = (state == FINISH);
   assign match_valid = (state == FINISH) ? ratio_ok : mv_r;
   assign best_idx    = idx;
   assign best_dist   = best;
   assign second_dist = second;

   // Controller: state sequencing plus beat and entry counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         beat  <= '0;
         entry <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  beat  <= '0;
                  entry <= '0;
                  state <= (num_entries == '0) ? FINISH : SCAN;
               end
            end
            SCAN: begin
               beat <= last_beat ? '0 : beat + 1'b1;
               if (last_beat) begin
                  if (last_entry) begin
                     entry <= '0;
                     state <= FINISH;
                  end else begin
                     entry <= entry + 1'b1;
                  end
               end
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath: query capture, SAD accumulation and best/second tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         query_r <= '0;
         num_r   <= '0;
         acc     <= '0;
         best    <= '1;
         second  <= '1;
         idx     <= '0;
         mv_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  query_r <= query;
                  num_r   <= num_entries;
                  best    <= '1;
                  second  <= '1;
                  idx     <= '0;
                  mv_r    <= 1'b0;
               end
            end
            SCAN: begin
               acc <= d;
               if (last_beat) begin
                  // Strict compares keep the lower index on ties.
                  if (d < best) begin
                     second <= best;
                     best   <= d;
                     idx    <= entry;
                  end else if (d < second) begin
                     second <= d;
                  end
               end
            end
            FINISH:  mv_r <= ratio_ok;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_descriptor_matcher.sv
// Scoreboard bench for descriptor_matcher: each search pushes its expected
// result, a monitor pops and compares whenever done is presented.
module tb_descriptor_matcher;

   localparam int ELEM_W     = 10;
   localparam int N_ELEM     = 128;
   localparam int ADDR_WIDTH = 5;
   localparam int DIST_W     = 17;
   localparam int DESC_W     = ELEM_W * N_ELEM;
   localparam logic [DIST_W-1:0] ONES = '1;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    start = 1'b0;
   logic [DESC_W-1:0]       query = '0;
   logic [ADDR_WIDTH:0]     num_entries = '0;
   logic [ADDR_WIDTH-1:0]   sram_addr;
   logic [DESC_W-1:0]       sram_q;
   logic                    busy;
   logic                    done;
   logic [ADDR_WIDTH-1:0]   best_idx;
   logic [DIST_W-1:0]       best_dist;
   logic [DIST_W-1:0]       second_dist;
   logic                    match_valid;

   logic [DESC_W-1:0]       mem [32];

   typedef struct {
      logic [ADDR_WIDTH-1:0] idx;
      logic [DIST_W-1:0]     best;
      logic [DIST_W-1:0]     second;
      logic                  mv;
      int                    done_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t got_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   descriptor_matcher dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .query       (query),
      .num_entries (num_entries),
      .sram_addr   (sram_addr),
      .sram_q      (sram_q),
      .busy        (busy),
      .done        (done),
      .best_idx    (best_idx),
      .best_dist   (best_dist),
      .second_dist (second_dist),
      .match_valid (match_valid)
   );

   assign sram_q = mem[sram_addr];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle count %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse consumes one expected result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: done=1 at cycle count %0d, expected 0", cyc);
         end else begin
            got_e = sb.pop_front();
            check("done_cycle",  32'(cyc),         32'(got_e.done_cyc));
            check("best_idx",    32'(best_idx),    32'(got_e.idx));
            check("best_dist",   32'(best_dist),   32'(got_e.best));
            check("second_dist", 32'(second_dist), 32'(got_e.second));
            check("match_valid", 32'(match_valid), 32'(got_e.mv));
         end
      end
   end

   task automatic set_elem(input int e, input int k, input int v);
      mem[e][k*ELEM_W +: ELEM_W] = ELEM_W'(v);
   endtask

   task automatic clear_all();
      query = '0;
      for (int e = 0; e < 32; e++) mem[e] = '0;
   endtask

   // Entry 3 equals the query, entries 0..2 are query+5 in every element.
   task automatic fill_test1();
      clear_all();
      for (int k = 0; k < N_ELEM; k++) begin
         query[k*ELEM_W +: ELEM_W] = ELEM_W'((k * 7) % 1000);
         for (int e = 0; e < 4; e++) set_elem(e, k, (e == 3) ? (k * 7) % 1000 : (k * 7) % 1000 + 5);
      end
   endtask

   // Zero query, entry e gets 'ones' elements equal to 1 (distance = ones).
   task automatic fill_ones(input int e, input int ones);
      for (int k = 0; k < ones; k++) set_elem(e, k, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},        32'(busy),        32'd0);
      check({tag, "_done"},        32'(done),        32'd0);
      check({tag, "_sram_addr"},   32'(sram_addr),   32'd0);
      check({tag, "_best_idx"},    32'(best_idx),    32'd0);
      check({tag, "_best_dist"},   32'(best_dist),   32'(ONES));
      check({tag, "_second_dist"}, 32'(second_dist), 32'(ONES));
      check({tag, "_match_valid"}, 32'(match_valid), 32'd0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
      if (busy) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: busy=1, expected 0");
      end
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: %0d results pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_search(input int n, input int eidx, input int eb, input int es,
                             input int emv, input bit chk_addr);
      exp_t e;
      int   c;
      int   kmax;
      wait_idle();
      num_entries = (ADDR_WIDTH+1)'(n);
      start       = 1'b1;
      c           = cyc;
      e.idx       = ADDR_WIDTH'(eidx);
      e.best      = DIST_W'(eb);
      e.second    = DIST_W'(es);
      e.mv        = emv[0];
      e.done_cyc  = c + 1 + 8 * n;
      sb.push_back(e);
      kmax = (n == 0) ? 1 : 8 * n;
      for (int k = 1; k <= kmax; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            check("busy_after_start", 32'(busy), 32'd1);
         end
         if (chk_addr) check("sram_addr_step", 32'(sram_addr), (n == 0) ? 32'd0 : 32'((k - 1) / 8));
      end
      wait_empty();
      @(negedge clk);
      check("best_dist_hold", 32'(best_dist), 32'(eb));
   endtask

   initial begin
      int c;
      clear_all();
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("idle");

      fill_test1();
      run_search(4, 3, 0, 640, 1, 1'b0);

      run_search(0, 0, 131071, 131071, 0, 1'b1);

      clear_all();
      fill_ones(0, 128);
      fill_ones(1, 128);
      run_search(2, 0, 128, 128, 0, 1'b0);

      clear_all();
      fill_ones(0, 80);
      fill_ones(1, 100);
      run_search(2, 0, 80, 100, 0, 1'b0);

      clear_all();
      fill_ones(0, 100);
      fill_ones(1, 79);
      run_search(2, 1, 79, 100, 1, 1'b0);

      clear_all();
      for (int e = 0; e < 32; e++) mem[e] = '1;
      run_search(32, 0, 130944, 130944, 0, 1'b1);

      // Abort a scan: ignored re-start at cycle 5, reset at cycle 10.
      fill_test1();
      wait_idle();
      num_entries = 6'd4;
      start       = 1'b1;
      c           = cyc;
      while (cyc < c + 10) begin
         @(negedge clk);
         if (cyc == c + 1) start = 1'b0;
         if (cyc == c + 5) begin
            num_entries = 6'd0;
            start       = 1'b1;
         end
         if (cyc == c + 6) start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_idle_busy", 32'(busy), 32'd0);
      run_search(4, 3, 0, 640, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
